// File: rtl/frame_loader_3.sv
// Three-slot frame loader: collects serial samples into o1..o3 and presents them as one frame
// to a downstream sorter with a valid/ready handshake and a delivered-frame counter.
module frame_loader_3 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [7:0]       frame_cnt
);

    typedef enum logic {
        StFill,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] o1_q, o1_d;
    logic [WIDTH-1:0] o2_q, o2_d;
    logic [WIDTH-1:0] o3_q, o3_d;
    logic             frame_valid_q, frame_valid_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             accept;

    assign in_ready = (state_q == StFill);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        o1_d          = o1_q;
        o2_d          = o2_q;
        o3_d          = o3_q;
        frame_valid_d = frame_valid_q;
        frame_cnt_d   = frame_cnt_q;

        // Flush wins over both a pending accept and a frame hand-off; slots are left untouched.
        if (flush) begin
            state_d       = StFill;
            slot_d        = 2'd0;
            frame_valid_d = 1'b0;
        end else if (state_q == StFull) begin
            if (frame_ready) begin
                state_d       = StFill;
                slot_d        = 2'd0;
                frame_valid_d = 1'b0;
                frame_cnt_d   = frame_cnt_q + 8'd1;
            end
        end else if (accept) begin
            case (slot_q)
                2'd0: begin
                    o1_d   = in_data;
                    slot_d = 2'd1;
                end
                2'd1: begin
                    o2_d   = in_data;
                    slot_d = 2'd2;
                end
                default: begin
                    o3_d          = in_data;
                    slot_d        = 2'd0;
                    state_d       = StFull;
                    frame_valid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFill;
            slot_q        <= 2'd0;
            o1_q          <= '0;
            o2_q          <= '0;
            o3_q          <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            o1_q          <= o1_d;
            o2_q          <= o2_d;
            o3_q          <= o3_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign o1          = o1_q;
    assign o2          = o2_q;
    assign o3          = o3_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frame_loader_3.sv
// Directed self-checking bench for frame_loader_3: fill, hold, consume, flush, wrap and reset.
module tb_frame_loader_3;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic [WIDTH-1:0] o3;
    logic             frame_valid;
    logic             frame_ready;
    logic [7:0]       frame_cnt;

    int errors = 0;
    int checks = 0;

    frame_loader_3 #(
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .o1         (o1),
        .o2         (o2),
        .o3         (o3),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [WIDTH-1:0] e1,
                               input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
        check({tag, "_o1"}, 32'(o1), 32'(e1));
        check({tag, "_o2"}, 32'(o2), 32'(e2));
        check({tag, "_o3"}, 32'(o3), 32'(e3));
    endtask

    task automatic check_zero(input string tag);
        check_frame(tag, '0, '0, '0);
        check({tag, "_fv"}, 32'(frame_valid), 32'd0);
        check({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    // Assert reset between edges and check the outputs clear without a clock edge.
    task automatic mid_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        #2;
        rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] tog_data [5];
    logic             tog_valid[5];
    int               pulses;
    logic             prev_fv;

    initial begin
        rst_n       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        frame_ready = 1'b0;
        #12;
        check_zero("reset");
        #2;
        rst_n = 1'b1;
        check({"post_rst_rdy"}, 32'(in_ready), 32'd1);

        // Basic fill: 2, 4, 1 on consecutive cycles.
        in_valid = 1'b1;
        in_data  = 4'd2;
        step();
        check("fill1_fv", 32'(frame_valid), 32'd0);
        in_data = 4'd4;
        step();
        in_data = 4'd1;
        step();
        check_frame("fill", 4'd2, 4'd4, 4'd1);
        check("fill_fv", 32'(frame_valid), 32'd1);
        check("fill_rdy", 32'(in_ready), 32'd0);
        check("fill_cnt", 32'(frame_cnt), 32'd0);

        // Held frame ignores further valid samples.
        in_data = 4'd7;
        for (int i = 0; i < 5; i++) step();
        check_frame("hold", 4'd2, 4'd4, 4'd1);
        check("hold_fv", 32'(frame_valid), 32'd1);
        in_valid    = 1'b0;
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("consume_fv", 32'(frame_valid), 32'd0);
        check("consume_rdy", 32'(in_ready), 32'd1);
        check("consume_cnt", 32'(frame_cnt), 32'd1);

        // frame_ready in FILL is ignored.
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("idle_ready_cnt", 32'(frame_cnt), 32'd1);

        // Flush beats a simultaneous accept.
        push(4'd9);
        push(4'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd5;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_fv", 32'(frame_valid), 32'd0);
        check("flush_rdy", 32'(in_ready), 32'd1);
        check("flush_o3_kept", 32'(o3), 32'd1);
        push(4'd6);
        check("flush_slot0_fv", 32'(frame_valid), 32'd0);
        push(4'd8);
        push(4'd0);
        check_frame("after_flush", 4'd6, 4'd8, 4'd0);
        check("after_flush_fv", 32'(frame_valid), 32'd1);

        // Flush beats frame_ready: frame dropped, not counted, slots kept.
        flush       = 1'b1;
        frame_ready = 1'b1;
        step();
        flush       = 1'b0;
        frame_ready = 1'b0;
        check("flush_full_fv", 32'(frame_valid), 32'd0);
        check("flush_full_cnt", 32'(frame_cnt), 32'd1);
        check_frame("flush_full", 4'd6, 4'd8, 4'd0);

        // Toggled in_valid: the invalid cycles must not take a slot.
        tog_data  = '{4'hF, 4'hA, 4'hE, 4'hB, 4'hD};
        tog_valid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            in_data  = tog_data[i];
            in_valid = tog_valid[i];
            step();
        end
        in_valid = 1'b0;
        check_frame("toggle", 4'hF, 4'hE, 4'hD);
        check("toggle_fv", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("toggle_cnt", 32'(frame_cnt), 32'd2);

        // 256 back-to-back frames from a clean reset: counter wraps, each valid lasts one cycle.
        rst_n = 1'b0;
        #2;
        rst_n       = 1'b1;
        in_valid    = 1'b1;
        frame_ready = 1'b1;
        pulses      = 0;
        prev_fv     = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            in_data = 4'(i);
            step();
            if (frame_valid && prev_fv) check("fv_one_cycle", 32'd1, 32'd0);
            if (frame_valid) pulses++;
            prev_fv = frame_valid;
            if (i == 1019) check("wrap_cnt255", 32'(frame_cnt), 32'd255);
        end
        in_valid    = 1'b0;
        frame_ready = 1'b0;
        check("wrap_pulses", 32'(pulses), 32'd256);
        check("wrap_cnt0", 32'(frame_cnt), 32'd0);
        check("wrap_fv", 32'(frame_valid), 32'd0);

        // Async reset mid-frame after one delivered frame: counter must clear too.
        push(4'd4);
        push(4'd5);
        push(4'd6);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("pre_rst_cnt", 32'(frame_cnt), 32'd1);
        push(4'd7);
        push(4'd8);
        mid_reset("rst_partial");
        push(4'd1);
        push(4'd2);
        push(4'd3);
        check_frame("rst_refill", 4'd1, 4'd2, 4'd3);
        check("rst_refill_fv", 32'(frame_valid), 32'd1);
        mid_reset("rst_full");
        push(4'd1);
        push(4'd2);
        push(4'd3);
        check_frame("rst_full_refill", 4'd1, 4'd2, 4'd3);
        check("rst_full_refill_cnt", 32'(frame_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
